// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster-order 3x3 window sequencer with two line buffers feeding a Sobel kernel.
// Optional geometry checker is compiled in when SOBEL_WIN_ERR_EN is defined; otherwise err_o is tied 0.

module sobel_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    pclk_i,
  input  logic                    rstn_i,
  input  logic                    fsync_i,
  input  logic                    rsync_i,
  input  logic [DATA_WIDTH-1:0]   pdata_i,
  output logic                    fsync_o,
  output logic                    rsync_o,
  output logic [9*DATA_WIDTH-1:0] window_o,
  output logic                    frame_done_o,
  output logic                    err_o,
  output logic [1:0]              state_o
);

  // Valid semantics: a pixel is taken on every edge where fsync_i && rsync_i (no backpressure);
  // rsync_o is high for exactly one cycle per window and window_o holds otherwise.

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  localparam logic [CW-1:0] W_C    = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] W_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] C2     = CW'(2);
  localparam logic [RW-1:0] H_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] R1     = RW'(1);
  localparam logic [RW-1:0] R2     = RW'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            fsync_q, rsync_q;
  logic [CW-1:0]   col_q, col_d, col_eff;
  logic [RW-1:0]   row_q, row_d, row_eff;

  logic            frame_start, fsync_fall, in_frame;
  logic            pix_req, accept, row_end_px, win_valid, last_pix;

  logic [AW-1:0]         lb_addr;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  // Left two columns of the window: t1/t2 row r-2, t4/t5 row r-1, t7/t8 row r.
  logic [DATA_WIDTH-1:0] t1_q, t2_q, t4_q, t5_q, t7_q, t8_q;

  logic [9*DATA_WIDTH-1:0] win_next, window_q;
  logic                    win_vld_q, done_q;

  always_comb begin
    frame_start = fsync_i & ~fsync_q;
    fsync_fall  = ~fsync_i & fsync_q;
    in_frame    = (state_q != ST_IDLE) | frame_start;
    col_eff     = frame_start ? '0 : col_q;
    row_eff     = frame_start ? '0 : row_q;
    pix_req     = fsync_i & rsync_i & in_frame;
    accept      = pix_req & (col_eff < W_C);
    row_end_px  = (state_q != ST_IDLE) & ~frame_start & fsync_i &
                  rsync_q & ~rsync_i & (col_q != '0);
    win_valid   = accept & (state_q == ST_RUN) & (row_eff >= R2) & (col_eff >= C2);
    last_pix    = (row_eff == H_LAST) & (col_eff == W_LAST);
    lb_addr     = accept ? col_eff[AW-1:0] : '0;
  end

  // Read-before-write: the combinational read returns the value before this edge's write.
  assign lb0_rd = lb0[lb_addr];
  assign lb1_rd = lb1[lb_addr];

  always_ff @(posedge pclk_i) begin
    if (accept) begin
      lb1[lb_addr] <= lb0_rd;
      lb0[lb_addr] <= pdata_i;
    end
  end

  // FSM: state register
  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_FILL: begin
          if (fsync_fall) state_d = ST_IDLE;
          else if (row_end_px && (row_q == R1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (fsync_fall) state_d = ST_IDLE;
          else if (row_end_px && (row_q == H_LAST)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    fsync_o = (state_q == ST_RUN);
    state_o = state_q;
  end

  always_comb begin
    col_d = col_eff;
    if (!rsync_i) begin
      col_d = '0;
    end else if (accept) begin
      col_d = col_eff + CW'(1);
    end
    row_d = row_eff;
    if (row_end_px) begin
      row_d = row_q + RW'(1);
    end
  end

  // fsync_q resets high so a reset released mid-frame does not look like a frame start.
  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fsync_q <= 1'b1;
      rsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      fsync_q <= fsync_i;
      rsync_q <= rsync_i;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign win_next = {pdata_i, t8_q, t7_q, lb0_rd, t5_q, t4_q, lb1_rd, t2_q, t1_q};

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      t1_q      <= '0;
      t2_q      <= '0;
      t4_q      <= '0;
      t5_q      <= '0;
      t7_q      <= '0;
      t8_q      <= '0;
      window_q  <= '0;
      win_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        t1_q <= t2_q;
        t2_q <= lb1_rd;
        t4_q <= t5_q;
        t5_q <= lb0_rd;
        t7_q <= t8_q;
        t8_q <= pdata_i;
      end
      if (win_valid) begin
        window_q <= win_next;
      end
      win_vld_q <= win_valid;
      done_q    <= win_valid & last_pix;
    end
  end

  assign window_o     = window_q;
  assign rsync_o      = win_vld_q;
  assign frame_done_o = done_q;

`ifdef SOBEL_WIN_ERR_EN
  logic err_q, cmpl_q, ovr_q, err_set, frame_cmpl;

  // cmpl_q/ovr_q catch extra rows that arrive after a frame completed but before fsync_i falls.
  always_comb begin
    frame_cmpl = (state_q == ST_RUN) & row_end_px & (row_q == H_LAST);
    err_set    = (row_end_px & (col_q != W_C)) |
                 (pix_req & (col_eff == W_C)) |
                 (fsync_fall & ((state_q != ST_IDLE) | ovr_q));
  end

  always_ff @(posedge pclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q  <= 1'b0;
      cmpl_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (frame_start || fsync_fall) begin
        cmpl_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (frame_cmpl) cmpl_q <= 1'b1;
        if ((state_q == ST_IDLE) && cmpl_q && fsync_i && rsync_i) ovr_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl at 8x6: image-array window model, expected queue, directed frame scenarios.
module tb_sobel_window_ctrl;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

`ifdef SOBEL_WIN_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          fsync = 1'b0;
  logic          rsync = 1'b0;
  logic [DW-1:0] pdata = '0;

  logic          fsync_o, rsync_o, frame_done_o, err_o;
  logic [71:0]   window_o;
  logic [1:0]    state_o;

  sobel_window_ctrl #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .pclk_i      (clk),
    .rstn_i      (rst_n),
    .fsync_i     (fsync),
    .rsync_i     (rsync),
    .pdata_i     (pdata),
    .fsync_o     (fsync_o),
    .rsync_o     (rsync_o),
    .window_o    (window_o),
    .frame_done_o(frame_done_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  logic [72:0] exp_q[$];
  logic [7:0]  img [H][W];
  logic [72:0] cmp_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          win_cnt  = 0;
  int          done_cnt = 0;
  logic        grab_first = 1'b0;
  logic        flat_mode  = 1'b0;
  logic [71:0] first_win  = '0;
  logic [7:0]  done_tap9  = '0;

  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tap(input logic [71:0] w, input int k);
    return int'(w[(k-1)*8 +: 8]);
  endfunction

  function automatic int sobel_gx(input logic [71:0] w);
    return (tap(w,3) + 2*tap(w,6) + tap(w,9)) - (tap(w,1) + 2*tap(w,4) + tap(w,7));
  endfunction

  function automatic int sobel_gy(input logic [71:0] w);
    return (tap(w,7) + 2*tap(w,8) + tap(w,9)) - (tap(w,1) + 2*tap(w,2) + tap(w,3));
  endfunction

  // Model: window for pixel (r,c) is the 3x3 block of the image ending at (r,c).
  task automatic push_exp(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = img[r-2+i][c-2+j];
    exp_q.push_back({(r == H-1) && (c == W-1), w});
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_without_window", frame_done_o & ~rsync_o, 1'b0);
      if (rsync_o) begin
        chk("fsync_o_with_window", fsync_o, 1'b1);
        if (exp_q.size() == 0) begin
          chk("unexpected_window", rsync_o, 1'b0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("window", {frame_done_o, window_o}, cmp_e);
        end
        if (grab_first) begin
          first_win  = window_o;
          grab_first = 1'b0;
        end
        if (frame_done_o) begin
          done_tap9 = window_o[71:64];
          done_cnt++;
        end
        if (flat_mode) begin
          chk("flat_taps", window_o, {9{8'h80}});
          chk("flat_gx", 128'(sobel_gx(window_o)), 128'(0));
          chk("flat_gy", 128'(sobel_gy(window_o)), 128'(0));
        end
        win_cnt++;
      end
    end
  end

  // Driver. stop_kind: 0 none, 1 drop fsync after (stop_r,stop_c), 2 reset after (stop_r,stop_c).
  task automatic run_frame(input logic flat, input int short_row, input int stop_r,
                           input int stop_c, input int stop_kind, input int tail_gap);
    int n;
    @(negedge clk);
    fsync = 1'b1;
    rsync = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < H; r++) begin
      n = (r == short_row) ? W-1 : W;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        rsync = 1'b1;
        pdata = flat ? 8'h80 : 8'(r*16 + c);
        img[r][c] = pdata;
        if (r >= 2 && c >= 2) push_exp(r, c);
        if (stop_kind == 1 && r == stop_r && c == stop_c) begin
          @(negedge clk);
          fsync = 1'b0;
          rsync = 1'b0;
          return;
        end
        if (stop_kind == 2 && r == stop_r && c == stop_c) begin
          @(posedge clk);
          #2;
          rst_n = 1'b0;
          exp_q.delete();
          #1;
          chk("rst_mid_fsync_o", fsync_o, 1'b0);
          chk("rst_mid_rsync_o", rsync_o, 1'b0);
          chk("rst_mid_window_o", window_o, 72'h0);
          chk("rst_mid_done_o", frame_done_o, 1'b0);
          chk("rst_mid_err_o", err_o, 1'b0);
          fsync = 1'b0;
          rsync = 1'b0;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          repeat (2) @(negedge clk);
          return;
        end
      end
      @(negedge clk);
      rsync = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    fsync = 1'b0;
    repeat (tail_gap - 1) @(negedge clk);
  endtask

  task automatic settle(input string name);
    repeat (4) @(negedge clk);
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int w0, d0, hi;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fsync_o", fsync_o, 1'b0);
    chk("rst_rsync_o", rsync_o, 1'b0);
    chk("rst_window_o", window_o, 72'h0);
    chk("rst_done_o", frame_done_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    chk("rst_state", state_o, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp frame
    w0 = win_cnt; d0 = done_cnt; grab_first = 1'b1;
    run_frame(1'b0, -1, -1, -1, 0, 3);
    settle("s1_queue_empty");
    chk("s1_windows", 128'(win_cnt - w0), 128'(24));
    chk("s1_done", 128'(done_cnt - d0), 128'(1));
    chk("s1_first_window", first_win, FIRST_WIN);
    chk("s1_done_tap9", done_tap9, 8'h57);
    chk("s1_fsync_o_idle", fsync_o, 1'b0);

    // Flat frame
    w0 = win_cnt; d0 = done_cnt; flat_mode = 1'b1;
    run_frame(1'b1, -1, -1, -1, 0, 3);
    settle("s2_queue_empty");
    flat_mode = 1'b0;
    chk("s2_windows", 128'(win_cnt - w0), 128'(24));
    chk("s2_done", 128'(done_cnt - d0), 128'(1));

    // fsync drop after row 3 col 4, then a full frame
    w0 = win_cnt; d0 = done_cnt;
    run_frame(1'b0, -1, 3, 4, 1, 3);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsync_o || fsync_o || frame_done_o) hi++;
    end
    chk("s3_quiet_after_drop", 128'(hi), 128'(0));
    chk("s3_windows_before_drop", 128'(win_cnt - w0), 128'(9));
    chk("s3_no_done", 128'(done_cnt - d0), 128'(0));
    w0 = win_cnt; d0 = done_cnt;
    run_frame(1'b0, -1, -1, -1, 0, 3);
    settle("s3_queue_empty");
    chk("s3_windows_after", 128'(win_cnt - w0), 128'(24));
    chk("s3_done_after", 128'(done_cnt - d0), 128'(1));

    // Reset mid-row in RUN, then a full frame
    run_frame(1'b0, -1, 3, 4, 2, 3);
    w0 = win_cnt; d0 = done_cnt; grab_first = 1'b1;
    run_frame(1'b0, -1, -1, -1, 0, 3);
    settle("s4_queue_empty");
    chk("s4_first_window", first_win, FIRST_WIN);
    chk("s4_windows", 128'(win_cnt - w0), 128'(24));
    chk("s4_done", 128'(done_cnt - d0), 128'(1));

    // Back-to-back frames with a 1-cycle fsync gap
    w0 = win_cnt; d0 = done_cnt;
    run_frame(1'b0, -1, -1, -1, 0, 1);
    run_frame(1'b0, -1, -1, -1, 0, 3);
    settle("s6_queue_empty");
    chk("s6_windows", 128'(win_cnt - w0), 128'(48));
    chk("s6_done", 128'(done_cnt - d0), 128'(2));
    chk("s6_err_clean", err_o, 1'b0);

    // Short last row (7 pixels), then a full frame
    w0 = win_cnt; d0 = done_cnt;
    run_frame(1'b0, H-1, -1, -1, 0, 3);
    settle("s5_queue_empty");
    chk("s5_windows", 128'(win_cnt - w0), 128'(23));
    chk("s5_no_done", 128'(done_cnt - d0), 128'(0));
    chk("s5_err_after_row", err_o, ERR_EN);
    w0 = win_cnt; d0 = done_cnt;
    run_frame(1'b0, -1, -1, -1, 0, 3);
    settle("s5_queue_empty_next");
    chk("s5_windows_next", 128'(win_cnt - w0), 128'(24));
    chk("s5_done_next", 128'(done_cnt - d0), 128'(1));
    chk("s5_err_sticky", err_o, ERR_EN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
